// File: rtl/async_fifo_reader.sv
// -----------------------------------------------------------------------------
// async_fifo_reader
//
// Read-side adapter for the dual-clock FIFO, running entirely in the FIFO read
// clock domain. It pops words from the FIFO's first-word-fall-through read port
// into a 2-entry skid buffer. It presents them downstream as a registered
// valid/ready stream with a frame delimiter, a synchronous flush and a running
// count of delivered words.
//
// Ports:
//   clk            in   read-domain clock (same as FIFO read_clk)
//   reset_n        in   asynchronous active-low reset
//   fifo_empty     in   FIFO empty flag
//   fifo_read_en   out  pop request to the FIFO (forced low during reset)
//   fifo_read_data in   FIFO head word, valid whenever fifo_empty=0
//   flush          in   synchronous discard of buffered words + frame restart
//   out_valid      out  stream word available (registered)
//   out_ready      in   downstream accepts the word
//   out_data       out  stream data (registered, buffer head)
//   out_last       out  final beat of the current frame (registered)
//   word_count     out  beats accepted downstream, wraps modulo 2^COUNT_WIDTH
// -----------------------------------------------------------------------------
module async_fifo_reader #(
    parameter int WIDTH       = 32,
    parameter int FRAME_LEN   = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fifo_empty,
    output logic                   fifo_read_en,
    input  logic [WIDTH-1:0]       fifo_read_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] word_count
);

    // Beat index needs at least one bit even when every frame is a single beat.
    localparam int            BW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

    // Buffer occupancy: 0, 1 or 2 words.
    logic [1:0]             r_count;
    logic [WIDTH-1:0]       r_head;
    logic [WIDTH-1:0]       r_tail;
    logic [BW-1:0]          r_beat;
    logic                   r_valid;
    logic                   r_last;
    logic [COUNT_WIDTH-1:0] r_wc;

    logic                   w_pop;
    logic                   w_accept;
    logic [1:0]             w_count_nxt;
    logic [WIDTH-1:0]       w_head_nxt;
    logic [WIDTH-1:0]       w_tail_nxt;
    logic [BW-1:0]          w_beat_nxt;
    logic [COUNT_WIDTH-1:0] w_wc_nxt;

    // The pop request never looks at out_ready, so downstream readiness has no
    // combinational path back into the FIFO. Reset gates it immediately.
    assign w_pop        = reset_n & ~fifo_empty & (r_count < 2'd2) & ~flush;
    assign w_accept     = r_valid & out_ready;
    assign fifo_read_en = w_pop;

    assign out_valid  = r_valid;
    assign out_data   = r_head;
    assign out_last   = r_last;
    assign word_count = r_wc;

    // Next-state computation for the skid buffer, frame position and counter.
    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_beat_nxt  = r_beat;
        w_wc_nxt    = r_wc;
        if (flush) begin
            // Flush wins over a same-cycle accept; slot contents are left as
            // don't-care and simply become invisible.
            w_count_nxt = 2'd0;
            w_beat_nxt  = {BW{1'b0}};
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_pop) begin
                        w_head_nxt  = fifo_read_data;
                        w_count_nxt = 2'd1;
                    end else begin
                        w_count_nxt = 2'd0;
                    end
                end
                2'd1: begin
                    if (w_pop && !w_accept) begin
                        w_tail_nxt  = fifo_read_data;
                        w_count_nxt = 2'd2;
                    end else if (w_pop && w_accept) begin
                        // Head leaves and is replaced in the same cycle: full rate.
                        w_head_nxt  = fifo_read_data;
                        w_count_nxt = 2'd1;
                    end else if (w_accept) begin
                        w_count_nxt = 2'd0;
                    end else begin
                        w_count_nxt = 2'd1;
                    end
                end
                2'd2: begin
                    if (w_accept) begin
                        w_head_nxt  = r_tail;
                        w_count_nxt = 2'd1;
                    end else begin
                        w_count_nxt = 2'd2;
                    end
                end
                default: begin
                    w_count_nxt = 2'd0;
                end
            endcase
            if (w_accept) begin
                w_beat_nxt = (r_beat == LAST_BEAT) ? {BW{1'b0}} : (r_beat + BW'(1));
                w_wc_nxt   = r_wc + COUNT_WIDTH'(1);
            end else begin
                w_beat_nxt = r_beat;
                w_wc_nxt   = r_wc;
            end
        end
    end

    // State registers; valid/last are registered from the next-state values so
    // every stream output comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_head  <= {WIDTH{1'b0}};
            r_tail  <= {WIDTH{1'b0}};
            r_beat  <= {BW{1'b0}};
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_wc    <= {COUNT_WIDTH{1'b0}};
        end else begin
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_beat  <= w_beat_nxt;
            r_valid <= (w_count_nxt != 2'd0);
            r_last  <= (w_count_nxt != 2'd0) && (w_beat_nxt == LAST_BEAT);
            r_wc    <= w_wc_nxt;
        end
    end

endmodule

// File: tb/tb_async_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_reader
//
// Drives two instances from one shared stimulus stream: a default instance
// (FRAME_LEN=4, COUNT_WIDTH=16) and a small one (FRAME_LEN=1, COUNT_WIDTH=4).
// The reference model keeps the FIFO and the output buffer as plain queues.
// It tracks frame position and delivered count as plain integers.
// -----------------------------------------------------------------------------
module tb_async_fifo_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_read_data = 32'h0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        rden0, rden1, valid0, valid1, last0, last1;
    logic [31:0] data0, data1;
    logic [15:0] wc0;
    logic [3:0]  wc1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] fifo_q[$];
    logic [31:0] buf_q[$];
    int unsigned pos   = 0;   // beats accepted since reset/flush
    int unsigned total = 0;   // beats accepted since reset

    always #5 clk = ~clk;

    async_fifo_reader #(.WIDTH(32), .FRAME_LEN(4), .COUNT_WIDTH(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .fifo_read_en(rden0), .fifo_read_data(fifo_read_data), .flush(flush),
        .out_valid(valid0), .out_ready(out_ready), .out_data(data0),
        .out_last(last0), .word_count(wc0)
    );

    async_fifo_reader #(.WIDTH(32), .FRAME_LEN(1), .COUNT_WIDTH(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .fifo_read_en(rden1), .fifo_read_data(fifo_read_data), .flush(flush),
        .out_valid(valid1), .out_ready(out_ready), .out_data(data1),
        .out_last(last1), .word_count(wc1)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, compare outputs to the model, then
    // advance the model across the active edge.
    task automatic step(input bit rdy, input bit fl, input bit hide);
        bit exp_valid, exp_pop, acc;
        @(negedge clk);
        out_ready      = rdy;
        flush          = fl;
        fifo_empty     = hide || (fifo_q.size() == 0);
        fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        #1;
        exp_valid = (buf_q.size() != 0);
        exp_pop   = reset_n && !fifo_empty && (buf_q.size() < 2) && !fl;
        check_eq("valid0", 64'(valid0), 64'(exp_valid));
        check_eq("valid1", 64'(valid1), 64'(exp_valid));
        check_eq("rden0", 64'(rden0), 64'(exp_pop));
        check_eq("rden1", 64'(rden1), 64'(exp_pop));
        if (exp_valid) begin
            check_eq("data0", 64'(data0), 64'(buf_q[0]));
            check_eq("data1", 64'(data1), 64'(buf_q[0]));
        end
        check_eq("last0", 64'(last0), 64'(exp_valid && ((pos % 4) == 3)));
        check_eq("last1", 64'(last1), 64'(exp_valid));
        check_eq("wc0", 64'(wc0), 64'(total % 65536));
        check_eq("wc1", 64'(wc1), 64'(total % 16));
        @(posedge clk);
        acc = exp_valid && rdy;
        if (fl) begin
            buf_q.delete();
            pos = 0;
        end else begin
            if (acc) begin
                void'(buf_q.pop_front());
                pos++;
                total++;
            end
            if (exp_pop) buf_q.push_back(fifo_q.pop_front());
        end
    endtask

    // Step until model FIFO and buffer are empty, bounded by max_cyc.
    task automatic drain(input int max_cyc, input int ready_pct, input int hide_pct);
        for (int c = 0; c < max_cyc && (fifo_q.size() != 0 || buf_q.size() != 0); c++) begin
            step($urandom_range(99) < ready_pct, 1'b0, $urandom_range(99) < hide_pct);
        end
        step(1'b1, 1'b0, 1'b0);
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        fifo_empty = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        reset_n    = 1'b0;
        #1;
        check_eq("rst_valid0", 64'(valid0), 64'd0);
        check_eq("rst_valid1", 64'(valid1), 64'd0);
        check_eq("rst_last0", 64'(last0), 64'd0);
        check_eq("rst_last1", 64'(last1), 64'd0);
        check_eq("rst_data0", 64'(data0), 64'd0);
        check_eq("rst_wc0", 64'(wc0), 64'd0);
        check_eq("rst_wc1", 64'(wc1), 64'd0);
        check_eq("rst_rden0", 64'(rden0), 64'd0);
        buf_q.delete();
        fifo_q.delete();
        pos   = 0;
        total = 0;
        @(posedge clk);
        #1;
        // Buffer is empty and FIFO claims data: only reset keeps the pop low.
        check_eq("rst_rden0_hold", 64'(rden0), 64'd0);
        check_eq("rst_rden1_hold", 64'(rden1), 64'd0);
        check_eq("rst_valid0_hold", 64'(valid0), 64'd0);
        @(negedge clk);
        reset_n    = 1'b1;
        fifo_empty = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Pre-loaded FIFO streamed at full rate.
        fifo_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        drain(20, 100, 0);
        check_eq("stream_wc0", 64'(wc0), 64'd4);

        // Backpressure: buffer fills to two and holds its head.
        fifo_q = '{32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        drain(20, 100, 0);

        // Bursty interleave against a 64-word incrementing source.
        for (int i = 0; i < 64; i++) fifo_q.push_back(32'h1000 + 32'(i));
        drain(1000, 50, 20);
        check_eq("burst_wc0", 64'(wc0), 64'd71);

        // Flush with two words buffered and more waiting in the FIFO.
        fifo_q = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6};
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        drain(30, 100, 0);

        // Mid-frame asynchronous reset with the buffer full.
        fifo_q = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        do_reset();

        // Counter wrap on the 4-bit instance after 17 beats.
        for (int i = 0; i < 17; i++) fifo_q.push_back(32'hD00 + 32'(i));
        drain(100, 100, 0);
        check_eq("wrap_wc1", 64'(wc1), 64'd1);
        check_eq("wrap_wc0", 64'(wc0), 64'd17);

        // Random mix including occasional flushes.
        for (int i = 0; i < 40; i++) fifo_q.push_back($urandom);
        for (int c = 0; c < 200; c++) begin
            step($urandom_range(99) < 60, $urandom_range(99) < 5, $urandom_range(99) < 15);
        end
        drain(300, 100, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
